// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, glyph table and slot-phase encoding for the
// seven-segment scan driver. Segment order {g,f,e,d,c,b,a}, 0 = lit.
// Build option: define SEG7_HEX_EN to render nibble codes 10..15 as A,b,C,d,E,F;
// otherwise those codes render blank.
package seg7_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG7_BLANK = 7'h7F;

   localparam seg7_t SEG7_0 = 7'h40;
   localparam seg7_t SEG7_1 = 7'h79;
   localparam seg7_t SEG7_2 = 7'h24;
   localparam seg7_t SEG7_3 = 7'h30;
   localparam seg7_t SEG7_4 = 7'h19;
   localparam seg7_t SEG7_5 = 7'h12;
   localparam seg7_t SEG7_6 = 7'h02;
   localparam seg7_t SEG7_7 = 7'h78;
   localparam seg7_t SEG7_8 = 7'h00;
   localparam seg7_t SEG7_9 = 7'h18;

`ifdef SEG7_HEX_EN
   localparam seg7_t SEG7_A = 7'h08;
   localparam seg7_t SEG7_B = 7'h03;
   localparam seg7_t SEG7_C = 7'h46;
   localparam seg7_t SEG7_D = 7'h21;
   localparam seg7_t SEG7_E = 7'h06;
   localparam seg7_t SEG7_F = 7'h0E;
`endif

   // Dead phase keeps all anodes off at the start of each digit slot.
   typedef enum logic {
      PH_DEAD  = 1'b0,
      PH_DRIVE = 1'b1
   } slot_phase_e;

   // Nibble to segment pattern; anything without a glyph renders blank.
   function automatic seg7_t seg7_glyph(input logic [3:0] nibble);
      seg7_t g;
      case (nibble)
         4'h0:    g = SEG7_0;
         4'h1:    g = SEG7_1;
         4'h2:    g = SEG7_2;
         4'h3:    g = SEG7_3;
         4'h4:    g = SEG7_4;
         4'h5:    g = SEG7_5;
         4'h6:    g = SEG7_6;
         4'h7:    g = SEG7_7;
         4'h8:    g = SEG7_8;
         4'h9:    g = SEG7_9;
`ifdef SEG7_HEX_EN
         4'hA:    g = SEG7_A;
         4'hB:    g = SEG7_B;
         4'hC:    g = SEG7_C;
         4'hD:    g = SEG7_D;
         4'hE:    g = SEG7_E;
         4'hF:    g = SEG7_F;
`endif
         default: g = SEG7_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: bundle between the score/round logic (master) and the
// display scan driver (slave), including the board-side display pins.
interface seg7_scan_driver_if #(
   parameter int NDIG = 4
);
   import seg7_pkg::*;

   logic [4*NDIG-1:0] value;
   logic              load;
   logic [NDIG-1:0]   dp_in;
   logic [NDIG-1:0]   blink_en;
   logic              lz_blank;
   seg7_t             seg_n;
   logic              dp_n;
   logic [NDIG-1:0]   an_n;
   logic              frame_start;

   modport master (
      output value, load, dp_in, blink_en, lz_blank,
      input  seg_n, dp_n, an_n, frame_start
   );

   modport slave (
      input  value, load, dp_in, blink_en, lz_blank,
      output seg_n, dp_n, an_n, frame_start
   );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble to segment decoder for the digit currently
// being scanned. Hex rendering follows the SEG7_HEX_EN build option.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output seg7_t      seg
);

   // Pure table lookup.
   always_comb begin
      seg = seg7_glyph(nibble);
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver with
// frame-atomic value reload, dead time, leading-zero blanking, per-digit
// decimal point and blink. Hex glyphs depend on SEG7_HEX_EN (see seg7_pkg).
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NDIG         = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int DEAD         = 500,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                clk,
   input  logic                rst,
   seg7_scan_driver_if.slave   bus
);

   localparam int CW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
   localparam int IW = (NDIG > 1)         ? $clog2(NDIG)         : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEAD_CNT  = CW'(DEAD);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);
   localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic              bphase_q, bphase_d;
   logic [4*NDIG-1:0] disp_val_q, disp_val_d;
   logic [NDIG-1:0]   disp_dp_q, disp_dp_d;
   logic [4*NDIG-1:0] stage_val_q, stage_val_d;
   logic [NDIG-1:0]   stage_dp_q, stage_dp_d;
   logic              pending_q, pending_d;
   seg7_t             seg_q, seg_d;
   logic              dp_n_q, dp_n_d;
   logic [NDIG-1:0]   an_n_q, an_n_d;
   logic              frame_start_q, frame_start_d;

   logic              frame_end;
   slot_phase_e       phase;
   logic [NDIG-1:0]   lz_mask;
   logic [3:0]        nibble_sel;
   logic              dp_sel;
   logic              blink_sel;
   logic              lz_sel;
   logic [NDIG-1:0]   an_sel;
   seg7_t             glyph;

   // Scan counters, staging/display reload and blink phase.
   always_comb begin
      frame_end   = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
      cnt_d       = cnt_q + 1'b1;
      idx_d       = idx_q;
      bcnt_d      = bcnt_q;
      bphase_d    = bphase_q;
      disp_val_d  = disp_val_q;
      disp_dp_d   = disp_dp_q;
      stage_val_d = stage_val_q;
      stage_dp_d  = stage_dp_q;
      pending_d   = pending_q;

      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      if (bus.load) begin
         stage_val_d = bus.value;
         stage_dp_d  = bus.dp_in;
         pending_d   = 1'b1;
      end

      // A load landing on the boundary bypasses staging so it is seen one cycle later.
      if (frame_end) begin
         if (bus.load) begin
            disp_val_d = bus.value;
            disp_dp_d  = bus.dp_in;
         end else if (pending_q) begin
            disp_val_d = stage_val_q;
            disp_dp_d  = stage_dp_q;
         end
         pending_d = 1'b0;

         if (bcnt_q == BCNT_LAST) begin
            bcnt_d   = '0;
            bphase_d = ~bphase_q;
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end
   end

   // Leading-zero mask and selection of the digit in the current slot.
   always_comb begin
      lz_mask    = '0;
      nibble_sel = '0;
      dp_sel     = 1'b0;
      blink_sel  = 1'b0;
      lz_sel     = 1'b0;
      an_sel     = '1;
      phase      = (cnt_q < DEAD_CNT) ? PH_DEAD : PH_DRIVE;

      for (int unsigned i = 0; i < NDIG; i++) begin
         // Digit i is a leading zero when it and everything above it is zero.
         lz_mask[i] = (i != 0) && ((disp_val_q >> (4 * i)) == '0);
      end

      for (int unsigned i = 0; i < NDIG; i++) begin
         if (idx_q == IW'(i)) begin
            nibble_sel = disp_val_q[4*i +: 4];
            dp_sel     = disp_dp_q[i];
            blink_sel  = bus.blink_en[i];
            lz_sel     = lz_mask[i];
            an_sel[i]  = 1'b0;
         end
      end
   end

   seg7_decode u_decode (
      .nibble (nibble_sel),
      .seg    (glyph)
   );

   // Next values for the registered display pins.
   always_comb begin
      seg_d         = SEG7_BLANK;
      dp_n_d        = 1'b1;
      an_n_d        = '1;
      frame_start_d = (cnt_q == '0) && (idx_q == '0);

      if (phase == PH_DRIVE) begin
         an_n_d = an_sel;
         // Blink blanks the whole digit incl. dp; anode stays driven.
         if (!(bphase_q && blink_sel)) begin
            seg_d  = (lz_sel && bus.lz_blank) ? SEG7_BLANK : glyph;
            dp_n_d = ~dp_sel;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         bcnt_q        <= '0;
         bphase_q      <= 1'b0;
         disp_val_q    <= '0;
         disp_dp_q     <= '0;
         stage_val_q   <= '0;
         stage_dp_q    <= '0;
         pending_q     <= 1'b0;
         seg_q         <= SEG7_BLANK;
         dp_n_q        <= 1'b1;
         an_n_q        <= '1;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         bcnt_q        <= bcnt_d;
         bphase_q      <= bphase_d;
         disp_val_q    <= disp_val_d;
         disp_dp_q     <= disp_dp_d;
         stage_val_q   <= stage_val_d;
         stage_dp_q    <= stage_dp_d;
         pending_q     <= pending_d;
         seg_q         <= seg_d;
         dp_n_q        <= dp_n_d;
         an_n_q        <= an_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.seg_n       = seg_q;
   assign bus.dp_n        = dp_n_q;
   assign bus.an_n        = an_n_q;
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of seg7_scan_driver with NDIG=4,
// SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2 (32-cycle frames).
module tb_seg7_scan_driver;

   localparam int NDIG         = 4;
   localparam int SCAN_DIV     = 8;
   localparam int DEAD         = 2;
   localparam int BLINK_FRAMES = 2;

   localparam logic [6:0] G_0   = 7'h40;
   localparam logic [6:0] G_1   = 7'h79;
   localparam logic [6:0] G_2   = 7'h24;
   localparam logic [6:0] G_3   = 7'h30;
   localparam logic [6:0] G_4   = 7'h19;
   localparam logic [6:0] G_5   = 7'h12;
   localparam logic [6:0] G_6   = 7'h02;
   localparam logic [6:0] G_7   = 7'h78;
   localparam logic [6:0] G_8   = 7'h00;
   localparam logic [6:0] G_BLK = 7'h7F;
`ifdef SEG7_HEX_EN
   localparam logic [6:0] G_A   = 7'h08;
   localparam logic [6:0] G_F   = 7'h0E;
`else
   localparam logic [6:0] G_A   = 7'h7F;
   localparam logic [6:0] G_F   = 7'h7F;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   seg7_scan_driver_if #(.NDIG(NDIG)) dif ();

   seg7_scan_driver #(
      .NDIG         (NDIG),
      .SCAN_DIV     (SCAN_DIV),
      .DEAD         (DEAD),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int          frames = 0;   // frame_start pulses seen since reset release
   int          pos    = 0;   // output slot position within the frame, 0..31

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock; sample 1 ns after the edge and track frame position.
   task automatic step();
      @(posedge clk);
      #1;
      if (dif.frame_start === 1'b1) begin
         frames++;
         pos = 0;
      end else begin
         pos++;
      end
   endtask

   task automatic sync(output int waited);
      waited = 0;
      do begin
         step();
         waited++;
      end while (dif.frame_start !== 1'b1 && waited < 40);
      if (dif.frame_start !== 1'b1) check("sync_timeout", {31'd0, dif.frame_start}, 32'd1);
   endtask

   task automatic goto_pos(input int p);
      int n;
      n = 0;
      while (pos < p && n < 64) begin
         step();
         n++;
      end
   endtask

   task automatic check_digit(input string tag, input int d, input logic [6:0] seg, input logic dpn);
      logic [3:0] an_exp;
      an_exp = ~(4'b0001 << d);
      goto_pos(8 * d + 4);
      check({tag, "_seg"}, {25'd0, dif.seg_n}, {25'd0, seg});
      check({tag, "_an"},  {28'd0, dif.an_n},  {28'd0, an_exp});
      check({tag, "_dp"},  {31'd0, dif.dp_n},  {31'd0, dpn});
   endtask

   task automatic frame4(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                         input logic [6:0] s1, input logic [6:0] s0, output int waited);
      sync(waited);
      check_digit({tag, "_d0"}, 0, s0, 1'b1);
      check_digit({tag, "_d1"}, 1, s1, 1'b1);
      check_digit({tag, "_d2"}, 2, s2, 1'b1);
      check_digit({tag, "_d3"}, 3, s3, 1'b1);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
      dif.value = v;
      dif.dp_in = dp;
      dif.load  = 1'b1;
      step();
      dif.load  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      int bp;

      dif.value    = '0;
      dif.load     = 1'b0;
      dif.dp_in    = '0;
      dif.blink_en = '0;
      dif.lz_blank = 1'b0;

      // Reset and release
      #12;
      check("rst_seg", {25'd0, dif.seg_n}, {25'd0, G_BLK});
      check("rst_an",  {28'd0, dif.an_n}, 32'hF);
      check("rst_dp",  {31'd0, dif.dp_n}, 32'd1);
      check("rst_fs",  {31'd0, dif.frame_start}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      frames = 0;
      check("rel_an0", {28'd0, dif.an_n}, 32'hF);
      step();
      check("rel_fs",  {31'd0, dif.frame_start}, 32'd1);
      check("rel_an1", {28'd0, dif.an_n}, 32'hF);
      check("rel_seg1", {25'd0, dif.seg_n}, {25'd0, G_BLK});
      step();
      check("rel_an2", {28'd0, dif.an_n}, 32'hF);
      check("rel_fs2", {31'd0, dif.frame_start}, 32'd0);
      step();
      check("rel_an3", {28'd0, dif.an_n}, 32'hE);
      check("rel_seg3", {25'd0, dif.seg_n}, {25'd0, G_0});
      sync(w);
      check("fs_first_gap", w, 32'd30);
      sync(w);
      check("fs_period", w, 32'd32);

      // Atomic mid-frame load
      goto_pos(10);
      do_load(16'h1234, 4'b0000);
      check_digit("atom_old_d2", 2, G_0, 1'b1);
      check_digit("atom_old_d3", 3, G_0, 1'b1);
      frame4("atom_new", G_1, G_2, G_3, G_4, w);

      // Overwrite of staged data before the boundary
      sync(w);
      goto_pos(5);
      do_load(16'h1111, 4'b0000);
      goto_pos(15);
      do_load(16'h2222, 4'b0000);
      check_digit("ovr_keep_d3", 3, G_1, 1'b1);
      frame4("ovr", G_2, G_2, G_2, G_2, w);

      // Load in the exact boundary cycle
      sync(w);
      goto_pos(30);
      do_load(16'h5678, 4'b0000);
      frame4("bnd", G_5, G_6, G_7, G_8, w);
      check("bnd_latency", w, 32'd1);

      // Leading-zero blanking
      dif.lz_blank = 1'b1;
      do_load(16'h0070, 4'b0000);
      frame4("lz_on", G_BLK, G_BLK, G_7, G_0, w);
      dif.lz_blank = 1'b0;
      frame4("lz_off", G_0, G_0, G_7, G_0, w);
      dif.lz_blank = 1'b1;
      do_load(16'h0000, 4'b0000);
      frame4("lz_all0", G_BLK, G_BLK, G_BLK, G_0, w);

      // Hex codes; nonzero hex nibble stops leading-zero blanking
      do_load(16'hA00F, 4'b0000);
      frame4("hex", G_A, G_0, G_0, G_F, w);
      dif.lz_blank = 1'b0;

      // Blink on digit 0, decimal point on digit 1
      do_load(16'h1234, 4'b0010);
      dif.blink_en = 4'b0001;
      for (int f = 0; f < 4; f++) begin
         sync(w);
         bp = ((frames - 1) / 2) % 2;
         check_digit("blk_d0", 0, (bp != 0) ? G_BLK : G_4, 1'b1);
         check_digit("blk_d1", 1, G_3, 1'b0);
         check_digit("blk_d2", 2, G_2, 1'b1);
      end
      dif.blink_en = 4'b0010;
      for (int f = 0; f < 2; f++) begin
         sync(w);
         bp = ((frames - 1) / 2) % 2;
         check_digit("blkdp_d1", 1, (bp != 0) ? G_BLK : G_3, (bp != 0) ? 1'b1 : 1'b0);
      end
      dif.blink_en = 4'b0000;

      // Asynchronous reset mid-slot with staged data pending
      sync(w);
      do_load(16'h9999, 4'b1111);
      goto_pos(12);
      #3;
      rst = 1'b1;
      #1;
      check("arst_seg", {25'd0, dif.seg_n}, {25'd0, G_BLK});
      check("arst_an",  {28'd0, dif.an_n}, 32'hF);
      check("arst_dp",  {31'd0, dif.dp_n}, 32'd1);
      check("arst_fs",  {31'd0, dif.frame_start}, 32'd0);
      @(posedge clk);
      #1;
      check("arst_hold_an", {28'd0, dif.an_n}, 32'hF);
      rst = 1'b0;
      frames = 0;
      pos = 0;
      frame4("post_rst", G_0, G_0, G_0, G_0, w);
      check("post_rst_fs", w, 32'd1);
      dif.blink_en = 4'b0001;
      sync(w);
      check_digit("post_rst_bp_f2", 0, G_0, 1'b1);
      sync(w);
      check_digit("post_rst_bp_f3", 0, G_BLK, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
